// File: rtl/busreq_mc_sm_if.sv
// Bus-request handshake bundle for busreq_mc_sm.
// master: the request sequencer (drives requests, grant and pulses).
// slave:  the DMA channels / bus side (drives enables, read permits, done).
interface busreq_mc_sm_if #(
    parameter int NCH = 2
);
    logic [NCH-1:0] dma_en;
    logic [NCH-1:0] wrt_req_en;
    logic [NCH-1:0] rd_ok;
    logic           req_done;
    logic           rd_req;
    logic           wr_req;
    logic [NCH-1:0] grant;
    logic [NCH-1:0] rd_update;
    logic [NCH-1:0] wr_update;
    logic [NCH-1:0] timeout_err;

    modport master (
        input  dma_en, wrt_req_en, rd_ok, req_done,
        output rd_req, wr_req, grant, rd_update, wr_update, timeout_err
    );

    modport slave (
        output dma_en, wrt_req_en, rd_ok, req_done,
        input  rd_req, wr_req, grant, rd_update, wr_update, timeout_err
    );
endinterface

// File: rtl/busreq_mc_sm.sv
// Multi-channel DMA bus request sequencer.
// Round-robin arbitration between NCH channels; each granted channel issues
// one write or read request, alternating when both are pending.
// Optional macro BUSREQ_TIMEOUT_EN adds a per-request timeout (TO_CYC cycles)
// that aborts a stuck request and pulses timeout_err for the owning channel.
// Without the macro requests wait for req_done indefinitely.
module busreq_mc_sm #(
    parameter int NCH    = 2,
    parameter int TO_CYC = 255
) (
    input  logic hclk,
    input  logic hreset,
    busreq_mc_sm_if.master bus
);

    localparam int PTR_W = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [2:0] {
        IDLE   = 3'b000,
        ARB    = 3'b001,
        WRREQ  = 3'b010,
        RDREQ  = 3'b011,
        WRDONE = 3'b110,
        RDDONE = 3'b111,
        ABORT  = 3'b100
    } state_t;

    state_t            state;
    logic [NCH-1:0]    grant;
    logic [PTR_W-1:0]  grant_idx;
    logic [PTR_W-1:0]  rr_ptr;
    logic [PTR_W-1:0]  next_ptr;
    logic [NCH-1:0]    last_op;
    logic [NCH-1:0]    eligible;
    logic              rd_req;
    logic              wr_req;
    logic [NCH-1:0]    rd_update;
    logic [NCH-1:0]    wr_update;
    logic              pick_found;
    logic [PTR_W-1:0]  pick_idx;
    logic              pick_write;

`ifdef BUSREQ_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TO_CYC - 1);
    logic [7:0]        to_cnt;
    logic [NCH-1:0]    timeout_err;
`endif

    // A channel competes only when enabled and it has something to do.
    always_comb begin
        eligible = bus.dma_en & (bus.wrt_req_en | bus.rd_ok);
    end

    // First eligible channel at or after the round-robin pointer, wrapping.
    always_comb begin
        int cand;
        cand       = 0;
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int k = 0; k < NCH; k++) begin
            cand = (int'(rr_ptr) + k) % NCH;
            if (!pick_found && eligible[cand[PTR_W-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = cand[PTR_W-1:0];
            end
        end
    end

    // Operation for the picked channel; last_op bit set means last was a write.
    always_comb begin
        if (bus.wrt_req_en[pick_idx] && bus.rd_ok[pick_idx]) begin
            pick_write = ~last_op[pick_idx];
        end else begin
            pick_write = bus.wrt_req_en[pick_idx];
        end
    end

    assign next_ptr = (int'(grant_idx) == NCH - 1) ? '0 : grant_idx + PTR_W'(1);

    // Sequencer state, grant, arbitration history and registered outputs.
    always_ff @(posedge hclk) begin
        if (hreset) begin
            state     <= IDLE;
            grant     <= '0;
            grant_idx <= '0;
            rr_ptr    <= '0;
            last_op   <= '0;
            rd_req    <= 1'b0;
            wr_req    <= 1'b0;
            rd_update <= '0;
            wr_update <= '0;
`ifdef BUSREQ_TIMEOUT_EN
            to_cnt      <= '0;
            timeout_err <= '0;
`endif
        end else begin
            rd_update <= '0;
            wr_update <= '0;
`ifdef BUSREQ_TIMEOUT_EN
            timeout_err <= '0;
`endif
            case (state)
                IDLE: begin
                    if (|bus.dma_en) begin
                        state <= ARB;
                    end
                end
                ARB: begin
                    if (!(|bus.dma_en)) begin
                        state <= IDLE;
                    end else if (pick_found) begin
                        grant     <= NCH'(1) << pick_idx;
                        grant_idx <= pick_idx;
`ifdef BUSREQ_TIMEOUT_EN
                        to_cnt    <= '0;
`endif
                        if (pick_write) begin
                            state  <= WRREQ;
                            wr_req <= 1'b1;
                        end else begin
                            state  <= RDREQ;
                            rd_req <= 1'b1;
                        end
                    end
                end
                WRREQ: begin
`ifdef BUSREQ_TIMEOUT_EN
                    to_cnt <= to_cnt + 8'd1;
`endif
                    if (bus.req_done) begin
                        state     <= WRDONE;
                        wr_req    <= 1'b0;
                        wr_update <= grant;
                    end
`ifdef BUSREQ_TIMEOUT_EN
                    else if (to_cnt == TO_LAST) begin
                        state       <= ABORT;
                        wr_req      <= 1'b0;
                        timeout_err <= grant;
                    end
`endif
                end
                RDREQ: begin
`ifdef BUSREQ_TIMEOUT_EN
                    to_cnt <= to_cnt + 8'd1;
`endif
                    if (bus.req_done) begin
                        state     <= RDDONE;
                        rd_req    <= 1'b0;
                        rd_update <= grant;
                    end
`ifdef BUSREQ_TIMEOUT_EN
                    else if (to_cnt == TO_LAST) begin
                        state       <= ABORT;
                        rd_req      <= 1'b0;
                        timeout_err <= grant;
                    end
`endif
                end
                WRDONE: begin
                    last_op[grant_idx] <= 1'b1;
                    rr_ptr             <= next_ptr;
                    grant              <= '0;
                    state              <= ARB;
                end
                RDDONE: begin
                    last_op[grant_idx] <= 1'b0;
                    rr_ptr             <= next_ptr;
                    grant              <= '0;
                    state              <= ARB;
                end
`ifdef BUSREQ_TIMEOUT_EN
                ABORT: begin
                    rr_ptr <= next_ptr;
                    grant  <= '0;
                    state  <= ARB;
                end
`endif
                default: begin
                    state  <= IDLE;
                    grant  <= '0;
                    rd_req <= 1'b0;
                    wr_req <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rd_req    = rd_req;
    assign bus.wr_req    = wr_req;
    assign bus.grant     = grant;
    assign bus.rd_update = rd_update;
    assign bus.wr_update = wr_update;
`ifdef BUSREQ_TIMEOUT_EN
    assign bus.timeout_err = timeout_err;
`else
    assign bus.timeout_err = '0;
`endif

endmodule
